hit_formatter: RTL and testbench
================================

HIT_FORMATTER -- requirements
Module: hit_formatter

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO word capacity (power of 2, 4..256).
REQ-002 SHALL have parameter MAX_ROW, default 223, meaning highest legal row address.
REQ-003 SHALL have port clk_out, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port data_in, input, 27, raw readout word of type t_data {col[5:0], row[8:0], le[5:0] gray, te[5:0] gray}.
REQ-006 SHALL have port data_in_strobe, input, 1, one-cycle qualifier for data_in.
REQ-007 SHALL have port dout, output, 27, t_hit {col[5:0], row[8:0], le[5:0] binary, tot[5:0]}.
REQ-008 SHALL have port dout_valid, output, 1, FIFO head valid.
REQ-009 SHALL have port dout_ready, input, 1, consumer accept; a pop occurs when dout_valid && dout_ready.
REQ-010 SHALL have port fifo_full, output, 1, FIFO occupancy == DEPTH.
REQ-011 SHALL have port hit_cnt, output, 16, accepted-hit count, saturating at 16'hFFFF.
REQ-012 SHALL have port drop_cnt, output, 16, overflow-dropped count, saturating.
REQ-013 SHALL have port err_cnt, output, 16, illegal-row count, saturating.

Function
REQ-014 SHALL register data_in on data_in_strobe into stage S1 (cycle N -> S1 valid at N+1).
REQ-015 S1 SHALL convert le and te from 6-bit Gray to binary (bin[5]=g[5], bin[i]=bin[i+1]^g[i]).
REQ-016 S1 SHALL compute tot = (te_bin - le_bin) mod 64; te_bin == le_bin gives tot 0; te_bin < le_bin wraps (le=60, te=3 -> tot=7).
REQ-017 SHALL write the S1 word into the FIFO at the edge ending cycle N+1, so dout_valid rises at N+2 when the FIFO was empty.
REQ-018 A word with row > MAX_ROW SHALL NOT be written and SHALL increment err_cnt.
REQ-019 A legal word arriving while the FIFO is full and no pop occurs in the same cycle SHALL be dropped and SHALL increment drop_cnt.
REQ-020 When full and a pop occurs in the same cycle, the write SHALL succeed and occupancy SHALL stay DEPTH.
REQ-021 When empty, a simultaneous write and pop SHALL NOT occur, because dout_valid is 0.
REQ-022 When 0 < occupancy < DEPTH, a simultaneous write and pop SHALL leave occupancy unchanged and preserve order.
REQ-023 Every successfully written word SHALL increment hit_cnt.
REQ-024 dout SHALL always show the oldest word, with first-word fall-through.
REQ-025 dout SHALL be held stable while dout_valid=1 and dout_ready=0.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 Back-to-back strobes on consecutive cycles SHALL be accepted without loss while space exists.

Reset
REQ-028 While reset=1, the block SHALL clear the FIFO, pointers and S1 valid, and drive dout_valid=0, fifo_full=0, hit_cnt=0, drop_cnt=0, err_cnt=0 and dout=0.
REQ-029 A strobe in the same cycle as reset SHALL be ignored.
REQ-030 Reset asserted mid-operation SHALL discard all queued words and the S1 word.
REQ-031 The first strobe after reset deassertion SHALL be processed normally.

Structure
REQ-032 The typedefs t_data and t_hit and the function gray2bin6 SHALL reside in shared package monopix_pkg.
REQ-033 FIFO storage, pointers and the full/empty logic SHALL be sub-module hit_fifo (parameter DEPTH, WIDTH=27); decode and counters SHALL remain in hit_formatter.

Verification
REQ-034 Single hit: strobe col=5, row=100, le=gray(10), te=gray(17), ready=1 -> dout_valid at N+2 with dout={5,100,10,7}; hit_cnt=1.
REQ-035 Wrap ToT: le=gray(60), te=gray(3) -> tot=7; le=te=gray(33) -> tot=0.
REQ-036 Overflow: ready=0, DEPTH+3 consecutive strobes -> fifo_full=1, drop_cnt=3, hit_cnt=DEPTH; draining returns the first DEPTH words in order.
REQ-037 Full with simultaneous pop: occupancy DEPTH, strobe and pop in the same cycle -> no drop, fifo_full remains 1, order preserved.
REQ-038 Illegal row: strobe with row=224 -> nothing written, err_cnt=1, dout_valid stays 0.
REQ-039 Reset mid-stream: 5 words queued, reset for 1 cycle -> dout_valid=0 and all counters 0; the next hit emerges alone.

Source files
------------

// File: rtl/monopix_pkg.sv
// rtl/monopix_pkg.sv - shared readout/hit word types and helpers for the hit formatter
package monopix_pkg;

    localparam int          HIT_W   = 27;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic [5:0] col;
        logic [8:0] row;
        logic [5:0] le;
        logic [5:0] te;
    } t_data;

    typedef struct packed {
        logic [5:0] col;
        logic [8:0] row;
        logic [5:0] le;
        logic [5:0] tot;
    } t_hit;

    function automatic logic [5:0] gray2bin6(input logic [5:0] g);
        logic [5:0] b;
        b[5] = g[5];
        for (int i = 4; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hit_formatter_if.sv
// rtl/hit_formatter_if.sv - stream bundle carrying formatted hits out of the FIFO
interface hit_formatter_if #(
    parameter int WIDTH = 27
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/hit_fifo.sv
// rtl/hit_fifo.sv - first-word fall-through hit FIFO with a stream read port
module hit_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    hit_formatter_if.master  rd
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             empty;
    logic             push;
    logic             pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == DEPTH_CNT);
        pop      = !empty && rd.tready;
        // a same-cycle pop frees the slot, so a full FIFO may still accept
        push     = wr_en && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        rd.tvalid = !empty;
        rd.tdata  = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/hit_formatter.sv
// rtl/hit_formatter.sv - decodes raw pixel readout words into hits and queues them
module hit_formatter
    import monopix_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MAX_ROW = 223
) (
    input  logic        clk_out,
    input  logic        reset,
    input  logic [26:0] data_in,
    input  logic        data_in_strobe,
    output logic [26:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        fifo_full,
    output logic [15:0] hit_cnt,
    output logic [15:0] drop_cnt,
    output logic [15:0] err_cnt
);
    hit_formatter_if #(.WIDTH(HIT_W)) rd_if ();

    t_data       din;
    t_hit        s1_hit_q, s1_hit_d;
    logic        s1_valid_q, s1_valid_d;
    logic [5:0]  le_bin;
    logic [5:0]  te_bin;
    logic        row_ok;
    logic        pop;
    logic        wr_en;
    logic        drop;
    logic        illegal;
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    hit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (HIT_W)
    ) u_fifo (
        .clk     (clk_out),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (s1_hit_q),
        .full    (fifo_full),
        .rd      (rd_if)
    );

    assign rd_if.tready = dout_ready;
    assign dout         = rd_if.tdata;
    assign dout_valid   = rd_if.tvalid;

    always_comb begin
        din        = t_data'(data_in);
        le_bin     = gray2bin6(din.le);
        te_bin     = gray2bin6(din.te);
        s1_valid_d = data_in_strobe;
        s1_hit_d   = s1_hit_q;
        if (data_in_strobe) begin
            s1_hit_d.col = din.col;
            s1_hit_d.row = din.row;
            s1_hit_d.le  = le_bin;
            // 6-bit subtraction wraps, giving the ToT modulo 64
            s1_hit_d.tot = te_bin - le_bin;
        end

        row_ok  = ({23'd0, s1_hit_q.row} <= MAX_ROW);
        pop     = dout_valid && dout_ready;
        wr_en   = s1_valid_q && row_ok && (!fifo_full || pop);
        drop    = s1_valid_q && row_ok && fifo_full && !pop;
        illegal = s1_valid_q && !row_ok;

        hit_cnt_d  = wr_en   ? sat_inc16(hit_cnt_q)  : hit_cnt_q;
        drop_cnt_d = drop    ? sat_inc16(drop_cnt_q) : drop_cnt_q;
        err_cnt_d  = illegal ? sat_inc16(err_cnt_q)  : err_cnt_q;
    end

    always_ff @(posedge clk_out) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= '0;
            hit_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_hit_q   <= s1_hit_d;
            hit_cnt_q  <= hit_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_hit_formatter.sv
// tb/tb_hit_formatter.sv - randomized self-checking bench for hit_formatter
module tb_hit_formatter;
    import monopix_pkg::*;

    localparam int DEPTH   = 16;
    localparam int MAX_ROW = 223;

    logic        clk_out = 1'b0;
    logic        reset;
    logic [26:0] data_in;
    logic        data_in_strobe;
    logic        fifo_full;
    logic [15:0] hit_cnt, drop_cnt, err_cnt;

    hit_formatter_if #(.WIDTH(27)) mon ();

    always #5 clk_out = ~clk_out;

    hit_formatter #(.DEPTH(DEPTH), .MAX_ROW(MAX_ROW)) dut (
        .clk_out        (clk_out),
        .reset          (reset),
        .data_in        (data_in),
        .data_in_strobe (data_in_strobe),
        .dout           (mon.tdata),
        .dout_valid     (mon.tvalid),
        .dout_ready     (mon.tready),
        .fifo_full      (fifo_full),
        .hit_cnt        (hit_cnt),
        .drop_cnt       (drop_cnt),
        .err_cnt        (err_cnt)
    );

    t_hit mq[$];
    int   m_hit, m_drop, m_err;
    bit   m_pend;
    t_hit m_pend_w;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [5:0] to_gray(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic t_hit expect_hit(input logic [5:0] col, input logic [8:0] row,
                                        input logic [5:0] le, input logic [5:0] te);
        t_hit h;
        h.col = col;
        h.row = row;
        h.le  = le;
        h.tot = 6'((int'(te) - int'(le) + 64) % 64);
        return h;
    endfunction

    task automatic model_edge(input bit stb, input t_hit w, input bit rdy);
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (m_pend) begin
            if (int'(m_pend_w.row) > MAX_ROW) begin
                if (m_err < 65535) m_err++;
            end else if (mq.size() < DEPTH) begin
                mq.push_back(m_pend_w);
                if (m_hit < 65535) m_hit++;
            end else begin
                if (m_drop < 65535) m_drop++;
            end
        end
        m_pend   = stb;
        m_pend_w = w;
    endtask

    task automatic tick(input bit stb, input logic [5:0] col, input logic [8:0] row,
                        input logic [5:0] le, input logic [5:0] te, input bit rdy);
        t_hit w;
        data_in_strobe = stb;
        data_in        = {col, row, to_gray(le), to_gray(te)};
        mon.tready     = rdy;
        w = expect_hit(col, row, le, te);
        @(posedge clk_out);
        model_edge(stb, w, rdy);
        #1;
        data_in_strobe = 1'b0;
    endtask

    task automatic rand_tick(input bit stb, input int row_hi, input bit rdy);
        tick(stb, 6'($urandom), 9'($urandom_range(0, row_hi)), 6'($urandom), 6'($urandom), rdy);
    endtask

    task automatic do_reset(input int cycles);
        reset          = 1'b1;
        data_in_strobe = 1'b1;
        data_in        = 27'($urandom);
        mon.tready     = 1'b1;
        repeat (cycles) @(posedge clk_out);
        mq.delete();
        m_hit = 0; m_drop = 0; m_err = 0; m_pend = 1'b0;
        #1;
        reset          = 1'b0;
        data_in_strobe = 1'b0;
        mon.tready     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; data_in_strobe = 1'b1; data_in = 27'($urandom); mon.tready = 1'b1;
        repeat (2) @(posedge clk_out);
        #1;
        checks++; if (mon.tvalid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", mon.tvalid); end
        checks++; if (mon.tdata !== 27'd0) begin errors++; $display("FAIL reset_dout got=%h exp=0", mon.tdata); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
        checks++; if ({hit_cnt, drop_cnt, err_cnt} !== 48'd0) begin
            errors++; $display("FAIL reset_counters got=%h/%h/%h exp=0/0/0", hit_cnt, drop_cnt, err_cnt);
        end
        mq.delete(); m_hit = 0; m_drop = 0; m_err = 0; m_pend = 1'b0;
        reset = 1'b0; data_in_strobe = 1'b0;
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        checks++; if (mon.tvalid !== 1'b0 || hit_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_strobe_ignored valid=%b hit=%0d exp valid=0 hit=0", mon.tvalid, hit_cnt);
        end
    endtask

    task automatic test_single_hit();
        do_reset(1);
        tick(1, 6'd5, 9'd100, 6'd10, 6'd17, 1);
        checks++; if (mon.tvalid !== 1'b0) begin errors++; $display("FAIL single_n1_valid got=%b exp=0", mon.tvalid); end
        tick(0, 0, 0, 0, 0, 1);
        checks++; if (mon.tvalid !== 1'b1) begin errors++; $display("FAIL single_n2_valid got=%b exp=1", mon.tvalid); end
        checks++; if (mon.tdata !== {6'd5, 9'd100, 6'd10, 6'd7}) begin
            errors++; $display("FAIL single_dout got=%h exp=%h", mon.tdata, {6'd5, 9'd100, 6'd10, 6'd7});
        end
        checks++; if (hit_cnt !== 16'd1) begin errors++; $display("FAIL single_hit_cnt got=%0d exp=1", hit_cnt); end
        tick(0, 0, 0, 0, 0, 1);
        checks++; if (mon.tvalid !== 1'b0) begin errors++; $display("FAIL single_popped got=%b exp=0", mon.tvalid); end
    endtask

    task automatic test_wrap_tot();
        do_reset(1);
        tick(1, 6'd1, 9'd2, 6'd60, 6'd3, 0);
        tick(1, 6'd4, 9'd5, 6'd33, 6'd33, 0);
        tick(0, 0, 0, 0, 0, 0);
        checks++; if (mon.tdata[5:0] !== 6'd7 || mon.tvalid !== 1'b1) begin
            errors++; $display("FAIL tot_wrap got=%0d valid=%b exp=7 valid=1", mon.tdata[5:0], mon.tvalid);
        end
        tick(0, 0, 0, 0, 0, 1);
        checks++; if (mon.tdata[5:0] !== 6'd0 || mon.tvalid !== 1'b1) begin
            errors++; $display("FAIL tot_equal got=%0d valid=%b exp=0 valid=1", mon.tdata[5:0], mon.tvalid);
        end
        for (int i = 0; i < 24; i++) begin
            if (mon.tvalid && mq.size() > 0) begin
                checks++; if (mon.tdata !== mq[0]) begin
                    errors++; $display("FAIL tot_stream i=%0d got=%h exp=%h", i, mon.tdata, mq[0]);
                end
            end
            rand_tick(i < 16, MAX_ROW, 1);
        end
        checks++; if (mon.tvalid !== 1'b0) begin errors++; $display("FAIL tot_drained got=%b exp=0", mon.tvalid); end
    endtask

    task automatic test_illegal_row();
        do_reset(1);
        tick(1, 6'd3, 9'd224, 6'd1, 6'd2, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 0, 1);
            checks++; if (mon.tvalid !== 1'b0) begin errors++; $display("FAIL illegal_valid i=%0d got=%b exp=0", i, mon.tvalid); end
        end
        checks++; if (err_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
            errors++; $display("FAIL illegal_counts err=%0d hit=%0d exp err=1 hit=0", err_cnt, hit_cnt);
        end
        tick(1, 6'd9, 9'd223, 6'd0, 6'd63, 0);
        tick(0, 0, 0, 0, 0, 0);
        checks++; if (mon.tvalid !== 1'b1 || mon.tdata !== {6'd9, 9'd223, 6'd0, 6'd63}) begin
            errors++; $display("FAIL max_row got=%h valid=%b exp=%h valid=1", mon.tdata, mon.tvalid, {6'd9, 9'd223, 6'd0, 6'd63});
        end
        tick(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_overflow();
        t_hit sent[$];
        logic [5:0] c, l, t;
        logic [8:0] r;
        do_reset(1);
        for (int i = 0; i < DEPTH + 3; i++) begin
            c = 6'($urandom); r = 9'($urandom_range(0, MAX_ROW)); l = 6'($urandom); t = 6'($urandom);
            sent.push_back(expect_hit(c, r, l, t));
            tick(1, c, r, l, t, 0);
        end
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", fifo_full); end
        checks++; if (drop_cnt !== 16'd3 || hit_cnt !== 16'(DEPTH)) begin
            errors++; $display("FAIL ovf_counts drop=%0d hit=%0d exp drop=3 hit=%0d", drop_cnt, hit_cnt, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (mon.tvalid !== 1'b1 || mon.tdata !== sent[i]) begin
                errors++; $display("FAIL ovf_drain i=%0d got=%h valid=%b exp=%h", i, mon.tdata, mon.tvalid, sent[i]);
            end
            tick(0, 0, 0, 0, 0, 1);
        end
        checks++; if (mon.tvalid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", mon.tvalid); end
    endtask

    task automatic test_full_pop();
        t_hit sent[$];
        logic [5:0] c, l, t;
        logic [8:0] r;
        do_reset(1);
        for (int i = 0; i < DEPTH + 5; i++) begin
            c = 6'($urandom); r = 9'($urandom_range(0, MAX_ROW)); l = 6'($urandom); t = 6'($urandom);
            sent.push_back(expect_hit(c, r, l, t));
        end
        for (int i = 0; i < DEPTH; i++) tick(1, sent[i].col, sent[i].row, sent[i].le, sent[i].le + sent[i].tot, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(1, sent[DEPTH].col, sent[DEPTH].row, sent[DEPTH].le, sent[DEPTH].le + sent[DEPTH].tot, 0);
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fpop_start got=%b exp=1", fifo_full); end
        for (int k = 1; k < 5; k++) begin
            tick(1, sent[DEPTH+k].col, sent[DEPTH+k].row, sent[DEPTH+k].le, sent[DEPTH+k].le + sent[DEPTH+k].tot, 1);
            checks++; if (fifo_full !== 1'b1 || drop_cnt !== 16'd0) begin
                errors++; $display("FAIL fpop_step k=%0d full=%b drop=%0d exp full=1 drop=0", k, fifo_full, drop_cnt);
            end
        end
        tick(0, 0, 0, 0, 0, 1);
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fpop_last got=%b exp=1", fifo_full); end
        for (int i = 5; i < DEPTH + 5; i++) begin
            checks++; if (mon.tvalid !== 1'b1 || mon.tdata !== sent[i]) begin
                errors++; $display("FAIL fpop_order i=%0d got=%h exp=%h", i, mon.tdata, sent[i]);
            end
            tick(0, 0, 0, 0, 0, 1);
        end
        checks++; if (hit_cnt !== 16'(DEPTH + 5) || drop_cnt !== 16'd0) begin
            errors++; $display("FAIL fpop_counts hit=%0d drop=%0d exp hit=%0d drop=0", hit_cnt, drop_cnt, DEPTH + 5);
        end
    endtask

    task automatic test_random();
        int rdy_pct;
        do_reset(1);
        for (int cyc = 0; cyc < 600; cyc++) begin
            rdy_pct = (cyc < 150) ? 20 : (cyc < 300) ? 85 : (cyc < 450) ? 50 : 97;
            checks++; if (mon.tvalid !== (mq.size() > 0)) begin
                errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, mon.tvalid, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                checks++; if (mon.tdata !== mq[0]) begin
                    errors++; $display("FAIL rand_dout cyc=%0d got=%h exp=%h", cyc, mon.tdata, mq[0]);
                end
            end
            checks++; if (fifo_full !== (mq.size() == DEPTH)) begin
                errors++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", cyc, fifo_full, mq.size() == DEPTH);
            end
            checks++; if (hit_cnt !== 16'(m_hit) || drop_cnt !== 16'(m_drop) || err_cnt !== 16'(m_err)) begin
                errors++; $display("FAIL rand_counts cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                                   cyc, hit_cnt, drop_cnt, err_cnt, m_hit, m_drop, m_err);
            end
            rand_tick($urandom_range(0, 99) < 70, 239, $urandom_range(0, 99) < rdy_pct);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset(1);
        for (int i = 0; i < 6; i++) rand_tick(1, MAX_ROW, 0);
        do_reset(1);
        checks++; if (mon.tvalid !== 1'b0 || fifo_full !== 1'b0) begin
            errors++; $display("FAIL mid_reset_state valid=%b full=%b exp 0/0", mon.tvalid, fifo_full);
        end
        checks++; if ({hit_cnt, drop_cnt, err_cnt} !== 48'd0) begin
            errors++; $display("FAIL mid_reset_counters got=%0d/%0d/%0d exp=0/0/0", hit_cnt, drop_cnt, err_cnt);
        end
        tick(1, 6'd33, 9'd17, 6'd20, 6'd25, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        checks++; if (mon.tvalid !== 1'b1 || mon.tdata !== {6'd33, 9'd17, 6'd20, 6'd5} || hit_cnt !== 16'd1) begin
            errors++; $display("FAIL mid_next_hit got=%h valid=%b hit=%0d exp=%h valid=1 hit=1",
                               mon.tdata, mon.tvalid, hit_cnt, {6'd33, 9'd17, 6'd20, 6'd5});
        end
        tick(0, 0, 0, 0, 0, 1);
        checks++; if (mon.tvalid !== 1'b0) begin errors++; $display("FAIL mid_alone got=%b exp=0", mon.tvalid); end
    endtask

    initial begin
        reset          = 1'b1;
        data_in_strobe = 1'b0;
        data_in        = '0;
        mon.tready     = 1'b0;
        m_hit = 0; m_drop = 0; m_err = 0; m_pend = 1'b0;
        test_reset();
        test_single_hit();
        test_wrap_tot();
        test_illegal_row();
        test_overflow();
        test_full_pop();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
